// File: rtl/irq_stim_gen.sv
// irq_stim_gen - multi-channel interrupt stimulus generator.
//
// Each channel watches the CPU macroscopic PC for a programmed target word.
// On a match it waits cfg_dly cycles and then raises its interrupt line. The
// line stays high until the handler writes that channel's ack word
// (ACK_BASE + 4*k). A channel fires at most cfg_limit times and then parks in
// DONE until it is reconfigured.
//
// Optional feature: define IRQ_TIMEOUT_EN to drop a line that has gone
// unacknowledged for TIMEOUT_CYC cycles. The channel then sets a sticky
// timeout_err bit and moves to DONE.
//
// Ports
//   clk, reset                      clock, async active-low reset
//   macroscopic_pc                  CPU PC, word compare ([1:0] ignored)
//   m_int_addr, m_int_byteen        ack write: address ([1:0] ignored), any byteen bit = valid
//   cfg_we, cfg_ch, cfg_pc,
//   cfg_dly, cfg_limit              per-channel configuration write
//   interrupt                       registered interrupt lines
//   fired_cnt                       per-channel assertion counts, ch k at [k*CNT_W +: CNT_W]
//   busy                            any channel in WAIT or ASSERT
//   timeout_err                     sticky per-channel timeout flags
module irq_stim_gen #(
  parameter int          N_CH        = 4,
  parameter int          CNT_W       = 4,
  parameter int          DLY_W       = 8,
  parameter logic [31:0] ACK_BASE    = 32'h7f20,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             macroscopic_pc,
  input  logic [31:0]             m_int_addr,
  input  logic [3:0]              m_int_byteen,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_ch,
  input  logic [31:0]             cfg_pc,
  input  logic [DLY_W-1:0]        cfg_dly,
  input  logic [CNT_W-1:0]        cfg_limit,
  output logic [N_CH-1:0]         interrupt,
  output logic [N_CH*CNT_W-1:0]   fired_cnt,
  output logic                    busy,
  output logic [N_CH-1:0]         timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

  logic            ack_vld;
  logic [29:0]     ack_word, pc_word;
  logic [N_CH-1:0] busy_ch;
  logic            unused_bits;

  assign ack_vld     = |m_int_byteen;
  assign ack_word    = m_int_addr[31:2];
  assign pc_word     = macroscopic_pc[31:2];
  assign busy        = |busy_ch;
  assign unused_bits = ^{macroscopic_pc[1:0], m_int_addr[1:0], cfg_pc[1:0]};

`ifndef IRQ_TIMEOUT_EN
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYC);
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [29:0] ACK_WORD = 30'((ACK_BASE >> 2) + 32'(k));

    state_e           state_q, state_d;
    logic [29:0]      tgt_q, tgt_d;
    logic [DLY_W-1:0] dly_q, dly_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d, fired_q, fired_d;
    logic             guard_q, guard_d, irq_q, irq_d;
    logic             hit, ack, cfg_hit, tmo_hit;

    assign hit     = (pc_word == tgt_q);
    assign ack     = ack_vld && (ack_word == ACK_WORD);
    assign cfg_hit = cfg_we && (cfg_ch == 3'(k));

`ifdef IRQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          terr_q, terr_d;
    // tmo_q counts completed cycles in ASSERT; the line drops at the edge
    // that would make it TIMEOUT_CYC.
    assign tmo_hit        = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign timeout_err[k] = terr_q;
`else
    assign tmo_hit        = 1'b0;
    assign timeout_err[k] = 1'b0;
`endif

    always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      fired_d = fired_q;
      irq_d   = irq_q;
      // Re-arm guard: released by any cycle where the PC is off target.
      guard_d = guard_q && hit;
`ifdef IRQ_TIMEOUT_EN
      terr_d  = terr_q;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (lim_q != '0 && fired_q < lim_q && hit && !guard_q) begin
            state_d = S_WAIT;
            cnt_d   = dly_q;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_ASSERT;
            irq_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - DLY_ONE;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            irq_d   = 1'b0;
            guard_d = 1'b1;
            fired_d = (fired_q == CNT_MAX) ? fired_q : fired_q + CNT_ONE;
            state_d = (CNT_W'(fired_q + CNT_ONE) == lim_q) ? S_DONE : S_IDLE;
          end else if (tmo_hit) begin
            irq_d   = 1'b0;
            state_d = S_DONE;
`ifdef IRQ_TIMEOUT_EN
            terr_d  = 1'b1;
`endif
          end
        end
        default: ;
      endcase
`ifdef IRQ_TIMEOUT_EN
      tmo_d = (state_q == S_ASSERT && state_d == S_ASSERT) ? tmo_q + TW'(1) : '0;
`endif
      // Configuration overrides every other same-cycle event on this channel.
      if (cfg_hit) begin
        state_d = S_IDLE;
        tgt_d   = cfg_pc[31:2];
        dly_d   = cfg_dly;
        lim_d   = cfg_limit;
        cnt_d   = '0;
        fired_d = '0;
        irq_d   = 1'b0;
        guard_d = 1'b0;
`ifdef IRQ_TIMEOUT_EN
        terr_d  = 1'b0;
        tmo_d   = '0;
`endif
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_IDLE;
        tgt_q   <= '0;
        dly_q   <= '0;
        cnt_q   <= '0;
        lim_q   <= '0;
        fired_q <= '0;
        guard_q <= 1'b0;
        irq_q   <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
        tmo_q   <= '0;
        terr_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        tgt_q   <= tgt_d;
        dly_q   <= dly_d;
        cnt_q   <= cnt_d;
        lim_q   <= lim_d;
        fired_q <= fired_d;
        guard_q <= guard_d;
        irq_q   <= irq_d;
`ifdef IRQ_TIMEOUT_EN
        tmo_q   <= tmo_d;
        terr_q  <= terr_d;
`endif
      end
    end

    assign interrupt[k]                  = irq_q;
    assign fired_cnt[k*CNT_W +: CNT_W]   = fired_q;
    assign busy_ch[k]                    = (state_q == S_WAIT) || (state_q == S_ASSERT);
  end

endmodule

// File: tb/tb_irq_stim_gen.sv
// tb_irq_stim_gen - directed scoreboard bench for irq_stim_gen.
// Each step() pushes the outputs expected after the coming clock edge and
// pops and compares them at posedge+1.
module tb_irq_stim_gen;
  localparam int N_CH = 4, CNT_W = 4, DLY_W = 8;

  logic                  clk = 1'b0, reset = 1'b0;
  logic [31:0]           macroscopic_pc = 32'h1000, m_int_addr = '0, cfg_pc = '0;
  logic [3:0]            m_int_byteen = '0;
  logic                  cfg_we = 1'b0;
  logic [2:0]            cfg_ch = '0;
  logic [DLY_W-1:0]      cfg_dly = '0;
  logic [CNT_W-1:0]      cfg_limit = '0;
  logic [N_CH-1:0]       interrupt, timeout_err;
  logic [N_CH*CNT_W-1:0] fired_cnt;
  logic                  busy;

  irq_stim_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W),
                 .ACK_BASE(32'h7f20), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pc(cfg_pc), .cfg_dly(cfg_dly),
    .cfg_limit(cfg_limit), .interrupt(interrupt), .fired_cnt(fired_cnt),
    .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  irq;
    logic [15:0] fired;
    logic        busy;
    logic [3:0]  terr;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  logic [3:0]  e_irq = '0, e_terr = '0;
  logic [15:0] e_fired = '0;
  logic        e_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".irq"},   32'(interrupt),   32'(e.irq));
    chk({e.tag, ".fired"}, 32'(fired_cnt),   32'(e.fired));
    chk({e.tag, ".busy"},  32'(busy),        32'(e.busy));
    chk({e.tag, ".terr"},  32'(timeout_err), 32'(e.terr));
  endtask

  // One clock: drive pc, expect e_* after the edge. Ack and cfg are one-shot.
  task automatic step(input string tag, input logic [31:0] pc);
    exp_t e;
    macroscopic_pc = pc;
    e.tag = tag; e.irq = e_irq; e.fired = e_fired; e.busy = e_busy; e.terr = e_terr;
    sb.push_back(e);
    @(posedge clk); #1;
    chk_all(sb.pop_front());
    cfg_we       = 1'b0;
    m_int_byteen = '0;
  endtask

  task automatic ack(input logic [31:0] a, input logic [3:0] ben);
    m_int_addr = a; m_int_byteen = ben;
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [31:0] pc,
                     input logic [7:0] dly, input logic [3:0] lim);
    cfg_we = 1'b1; cfg_ch = ch; cfg_pc = pc; cfg_dly = dly; cfg_limit = lim;
  endtask

  initial begin
    exp_t z;
    z.tag = "reset"; z.irq = '0; z.fired = '0; z.busy = 1'b0; z.terr = '0;
    #3 chk_all(z);
    @(posedge clk); #1 reset = 1'b1;

    // 1: single shot, dly 0
    cfg(0, 32'h3010, 0, 1);           step("t1cfg", 32'h1000);
    e_busy = 1;                        step("t1match", 32'h3010);
    e_irq = 4'b0001;                   step("t1rise", 32'h1000);
                                       step("t1hold", 32'h1000);
    ack(32'h7f20, 4'hf); e_irq = 0; e_fired = 16'h0001; e_busy = 0;
                                       step("t1ack", 32'h1000);
                                       step("t1done0", 32'h3010);
                                       step("t1done1", 32'h1000);

    // 2: dly 3, limit 2, re-arm guard
    cfg(1, 32'h3020, 3, 2);           step("t2cfg", 32'h1000);
    e_busy = 1;                        step("t2match", 32'h3020);
    for (int i = 0; i < 3; i++)        step("t2wait", 32'h3020);
    e_irq = 4'b0010;                   step("t2rise", 32'h3020);
                                       step("t2hold", 32'h3020);
    ack(32'h7f24, 4'hf); e_irq = 0; e_fired = 16'h0011; e_busy = 0;
                                       step("t2ack", 32'h3020);
                                       step("t2guard0", 32'h3020);
                                       step("t2guard1", 32'h3020);
                                       step("t2leave", 32'h1000);
    e_busy = 1;                        step("t2rematch", 32'h3020);
    for (int i = 0; i < 3; i++)        step("t2wait2", 32'h1000);
    e_irq = 4'b0010;                   step("t2rise2", 32'h1000);
    ack(32'h7f24, 4'hf); e_irq = 0; e_fired = 16'h0021; e_busy = 0;
                                       step("t2ack2", 32'h1000);
                                       step("t2done", 32'h3020);
    // out-of-range channel config is ignored
    cfg(5, 32'h1000, 0, 1);           step("cfgch5", 32'h1000);
                                       step("cfgch5b", 32'h1000);

    // 3: ch0 and ch2 share a target
    cfg(0, 32'h3040, 0, 3); e_fired = 16'h0020; step("t3cfg0", 32'h1000);
    cfg(2, 32'h3040, 0, 1);           step("t3cfg2", 32'h1000);
    e_busy = 1;                        step("t3match", 32'h3040);
    e_irq = 4'b0101;                   step("t3rise", 32'h1000);
    ack(32'h7f28, 4'hf); e_irq = 4'b0001; e_fired = 16'h0120;
                                       step("t3ack2", 32'h1000);
    ack(32'h7f2c, 4'hf);               step("t3ack3", 32'h1000);

    // 4: byte enables and low address bits
    ack(32'h7f20, 4'h0);               step("t4ben0", 32'h1000);
    ack(32'h7f23, 4'b0001); e_irq = 0; e_fired = 16'h0121; e_busy = 0;
                                       step("t4lowbits", 32'h1000);
                                       step("t4idle", 32'h1000);
    e_busy = 1;                        step("t4rematch", 32'h3040);
    e_irq = 4'b0001;                   step("t4rise", 32'h1000);
    // config and ack in the same cycle: config wins, count cleared
    cfg(0, 32'h3050, 0, 1); ack(32'h7f20, 4'hf);
    e_irq = 0; e_fired = 16'h0120; e_busy = 0;
                                       step("t4cfgwin", 32'h1000);

    // 5: async reset while a line is high
    cfg(1, 32'h3060, 1, 2); e_fired = 16'h0100; step("t5cfg", 32'h1000);
    e_busy = 1;                        step("t5match", 32'h3060);
                                       step("t5wait", 32'h3060);
    e_irq = 4'b0010;                   step("t5rise", 32'h3060);
    #2 reset = 1'b0;
    #1 z.tag = "t5async"; chk_all(z);
    @(posedge clk); #1 reset = 1'b1;
    e_irq = 0; e_fired = 0; e_busy = 0;
    for (int i = 0; i < 3; i++)        step("t5norearm", 32'h3060);

    // 6: unacknowledged line
    cfg(0, 32'h3070, 0, 1);           step("t6cfg", 32'h1000);
    e_busy = 1;                        step("t6match", 32'h3070);
    e_irq = 4'b0001;                   step("t6rise", 32'h1000);
`ifdef IRQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++)       step("t6hold", 32'h1000);
    e_irq = 0; e_busy = 0; e_terr = 4'b0001;
                                       step("t6timeout", 32'h1000);
                                       step("t6after", 32'h3070);
`else
    for (int i = 0; i < 20; i++)       step("t6hold", 32'h1000);
    ack(32'h7f20, 4'hf); e_irq = 0; e_busy = 0; e_fired = 16'h0001;
                                       step("t6ack", 32'h1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
